// File: rtl/seg7_display_controller_pkg.sv
// Shared constants and slot-state encoding
// for the 7-segment scan controller.
package seg7_display_controller_pkg;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [31:0] ANODE_OFF = '1;

  typedef enum logic [1:0] {
    GUARD = 2'b01,
    DRIVE = 2'b10
  } slot_t;

endpackage

// File: rtl/seg7_display_controller_if.sv
// Valid/ready load port carrying the hex word
// from the numeric datapath into the controller.
interface seg7_display_controller_if #(
  parameter int DW = 32
);

  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/seg7_display_controller_decoder.sv
// Hex nibble to active-low a..g segment decoder
// (0-9, A, b, C, d, E, F glyphs).
module hex_to_7segment_decoder (
  input  logic [3:0] hex,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  // glyph lookup, 0 = segment lit
  always_comb begin
    {a, b, c, d, e, f, g} = 7'h7F;
    unique case (hex)
      4'h0: {a, b, c, d, e, f, g} = 7'b0000001;
      4'h1: {a, b, c, d, e, f, g} = 7'b1001111;
      4'h2: {a, b, c, d, e, f, g} = 7'b0010010;
      4'h3: {a, b, c, d, e, f, g} = 7'b0000110;
      4'h4: {a, b, c, d, e, f, g} = 7'b1001100;
      4'h5: {a, b, c, d, e, f, g} = 7'b0100100;
      4'h6: {a, b, c, d, e, f, g} = 7'b0100000;
      4'h7: {a, b, c, d, e, f, g} = 7'b0001111;
      4'h8: {a, b, c, d, e, f, g} = 7'b0000000;
      4'h9: {a, b, c, d, e, f, g} = 7'b0000100;
      4'hA: {a, b, c, d, e, f, g} = 7'b0001000;
      4'hB: {a, b, c, d, e, f, g} = 7'b1100000;
      4'hC: {a, b, c, d, e, f, g} = 7'b0110001;
      4'hD: {a, b, c, d, e, f, g} = 7'b1000010;
      4'hE: {a, b, c, d, e, f, g} = 7'b0110000;
      4'hF: {a, b, c, d, e, f, g} = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/seg7_display_controller.sv
// Multiplexed 8-digit common-anode scan controller
// with frame-aligned commit and guard blanking.
module seg7_display_controller
  import seg7_display_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_display_controller_if.slave ld,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DIV_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GRD_LAST =
    CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    ANODE_OFF[NUM_DIGITS-1:0];

  logic [CW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  slot_t                 st;
  slot_t                 st_nxt;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         disp;
  logic                  pending;
  logic                  ready_q;
  logic                  slot_end;
  logic                  boundary;
  logic                  take;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);
  assign take     = ld.data_valid && ready_q;

  assign ld.data_ready = ready_q;

  // slot divider and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // slot state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= GUARD;
    else       st <= st_nxt;
  end

  // guard -> drive -> guard within each slot
  always_comb begin
    st_nxt = st;
    unique case (st)
      GUARD: if (div_cnt == GRD_LAST) st_nxt = DRIVE;
      DRIVE: if (slot_end)            st_nxt = GUARD;
      default:                        st_nxt = GUARD;
    endcase
  end

  // pick the nibble of the digit being scanned
  always_comb begin
    nib = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) nib = disp[4*k +: 4];
    end
  end

  hex_to_7segment_decoder u_dec (
    .hex (nib),
    .a   (dec_seg[6]),
    .b   (dec_seg[5]),
    .c   (dec_seg[4]),
    .d   (dec_seg[3]),
    .e   (dec_seg[2]),
    .f   (dec_seg[1]),
    .g   (dec_seg[0])
  );

  // pin values for the current slot state
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (st == DRIVE && !blank_mask[idx]) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = dec_seg;
      dp_nxt      = !dp_mask[idx];
    end
  end

  // registered pins keep anode and seg aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode      <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

  // shadow load and tear-free commit at frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      ready_q <= 1'b1;
    end else if (take) begin
      shadow  <= ld.data_in;
      pending <= 1'b1;
      ready_q <= 1'b0;
    end else if (boundary && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_display_controller.sv
// Directed plus random bench for the scan controller
// against a time-indexed behavioural display model.
module tb_seg7_display_controller;

  localparam int N = 8;
  localparam int R = 8;
  localparam int G = 2;
  localparam int F = N * R;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] blank_mask;
  logic [7:0] dp_mask;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;
  logic       v_valid;
  logic [31:0] v_data;

  seg7_display_controller_if #(.DW(32)) ld ();

  assign ld.data_in    = v_data;
  assign ld.data_valid = v_valid;

  seg7_display_controller #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (ld),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int checks = 0;
  int errors = 0;

  // model: k = clock edges since reset release
  int          k;
  logic [31:0] m_shadow;
  logic [31:0] m_disp;
  bit          m_pending;
  logic [31:0] tx_q [$];
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;
  logic        e_rdy;

  // frame measurement results
  int          lows [8];
  int          runs [8];
  int          multi;
  int          dpl;
  int          dpb;
  int          gbad;
  logic [6:0]  s0;
  logic [6:0]  s7;
  int          first_fd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h at %0t",
             tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    m_shadow  = '0;
    m_disp    = '0;
    m_pending = 1'b0;
    tx_q.delete();
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fd  = 1'b0;
    e_rdy = 1'b1;
  endtask

  // what the pins must show after the edge at time k
  task automatic model_edge();
    int ph;
    int sl;
    bit lit;
    bit xfer;
    ph   = k % R;
    sl   = (k / R) % N;
    lit  = (ph >= G) && !blank_mask[sl];
    xfer = v_valid && !m_pending;
    e_an  = lit ? ~(8'b1 << sl) : 8'hFF;
    e_seg = lit ? seg_tab[m_disp[4*sl +: 4]] : 7'h7F;
    e_dp  = lit ? !dp_mask[sl] : 1'b1;
    e_fd  = (k % F) == F - 1;
    if (e_fd && m_pending) begin
      m_disp    = m_shadow;
      m_pending = 1'b0;
    end else if (xfer) begin
      m_shadow  = v_data;
      m_pending = 1'b1;
      void'(tx_q.pop_front());
    end
    e_rdy = !m_pending;
    k++;
  endtask

  task automatic check_outs();
    chk("anode", {24'h0, anode}, {24'h0, e_an});
    chk("seg", {25'h0, seg}, {25'h0, e_seg});
    chk("dp", {31'h0, dp}, {31'h0, e_dp});
    chk("frame_done", {31'h0, frame_done},
        {31'h0, e_fd});
    chk("data_ready", {31'h0, ld.data_ready},
        {31'h0, e_rdy});
  endtask

  task automatic drive();
    v_valid = tx_q.size() > 0;
    v_data  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
    drive();
  endtask

  task automatic align_frame();
    for (int i = 0; i < F; i++) begin
      if (k % F == 0) break;
      step();
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8 * F; i++) begin
      if (tx_q.size() == 0 && ld.data_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, {31'h0, ok}, 32'h1);
  endtask

  task automatic measure_frame();
    logic [7:0] prev;
    prev  = anode;
    multi = 0;
    dpl   = 0;
    dpb   = 0;
    gbad  = 0;
    s0    = 7'h7F;
    s7    = 7'h7F;
    for (int d = 0; d < 8; d++) begin
      lows[d] = 0;
      runs[d] = 0;
    end
    for (int i = 0; i < F; i++) begin
      step();
      for (int d = 0; d < 8; d++) begin
        if (!anode[d]) lows[d]++;
        if (prev[d] && !anode[d]) runs[d]++;
      end
      if ($countones(~anode) > 1) multi++;
      if (!anode[0]) s0 = seg;
      if (!anode[7]) s7 = seg;
      if (anode == 8'hFF && seg !== 7'h7F) gbad++;
      if (dp === 1'b0) begin
        dpl++;
        if (anode[1] !== 1'b0) dpb++;
      end
      prev = anode;
    end
  endtask

  task automatic find_first_fd();
    first_fd = -1;
    for (int i = 0; i < 2 * F; i++) begin
      step();
      if (frame_done === 1'b1) begin
        first_fd = k;
        break;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    v_valid    = 1'b0;
    v_data     = '0;
    blank_mask = '0;
    dp_mask    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_anode", {24'h0, anode}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'h1);
    chk("rst_fd", {31'h0, frame_done}, 32'h0);
    chk("rst_ready", {31'h0, ld.data_ready}, 32'h1);
    reset = 1'b0;
    check_outs();

    // load 0123_4567 at cycle 3
    step();
    step();
    tx_q.push_back(32'h0123_4567);
    drive();
    find_first_fd();
    chk("first_fd_edge", first_fd, F);
    align_frame();
    measure_frame();
    chk("d0_is_7", {25'h0, s0}, 32'b0001111);
    chk("d7_is_0", {25'h0, s7}, 32'b0000001);
    for (int d = 0; d < 8; d++) begin
      chk("lit_cycles", lows[d], R - G);
      chk("lit_runs", runs[d], 1);
    end
    chk("two_anodes", multi, 0);
    chk("guard_seg", gbad, 0);

    // back-pressure: second word held off
    tx_q.push_back(32'hAAAA_AAAA);
    tx_q.push_back(32'hFFFF_FFFF);
    drive();
    wait_idle("bp_timeout");
    align_frame();
    measure_frame();
    chk("bp_d0_F", {25'h0, s0}, 32'b0111000);
    chk("bp_d7_F", {25'h0, s7}, 32'b0111000);

    // masks
    blank_mask = 8'h81;
    dp_mask    = 8'h02;
    align_frame();
    measure_frame();
    chk("blank_an0", lows[0], 0);
    chk("blank_an7", lows[7], 0);
    chk("dp_lit", dpl, R - G);
    chk("dp_only_an1", dpb, 0);
    blank_mask = '0;
    dp_mask    = '0;

    // random loads and masks
    for (int i = 0; i < 1500; i++) begin
      if (tx_q.size() == 0 &&
          $urandom_range(0, 40) == 0) begin
        tx_q.push_back($urandom);
        drive();
      end
      if ($urandom_range(0, 50) == 0) begin
        blank_mask = 8'($urandom & $urandom);
        dp_mask    = 8'($urandom);
      end
      step();
    end
    blank_mask = '0;
    dp_mask    = '0;

    // load exactly on the boundary cycle
    wait_idle("pre_idle_timeout");
    tx_q.push_back(32'h1111_1111);
    drive();
    wait_idle("one_idle_timeout");
    for (int i = 0; i < F; i++) begin
      if (k % F == F - 1) break;
      step();
    end
    tx_q.push_back(32'h89AB_CDEF);
    drive();
    step();
    chk("bnd_accepted", {31'h0, ld.data_ready}, 32'h0);
    measure_frame();
    chk("bnd_old_d0", {25'h0, s0}, 32'b1001111);
    measure_frame();
    chk("bnd_new_d0", {25'h0, s0}, 32'b0111000);
    chk("bnd_new_d7", {25'h0, s7}, 32'b0000000);

    // async reset mid-drive with a load in flight
    for (int i = 0; i < R; i++) begin
      if (k % R == 4) break;
      step();
    end
    tx_q.push_back(32'h5555_5555);
    drive();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_anode", {24'h0, anode}, 32'hFF);
    chk("arst_seg", {25'h0, seg}, 32'h7F);
    chk("arst_dp", {31'h0, dp}, 32'h1);
    chk("arst_ready", {31'h0, ld.data_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive();
    check_outs();
    find_first_fd();
    chk("rst_first_fd", first_fd, F);
    align_frame();
    measure_frame();
    chk("rst_d0_zero", {25'h0, s0}, 32'b0000001);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
